// File: rtl/pdp8_mem_pkg.sv
// Shared types and constants for the PDP-8 memory path on the s3board SRAMs.
package pdp8_mem_pkg;

  localparam int SRAM_A_W = 18;
  localparam int SRAM_D_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_WR_HOLD,
    S_DONE
  } mem_state_e;

endpackage

// File: rtl/pdp8_sram_bank.sv
// One SRAM bank: registered chip/byte enables and the registered tri-state data driver.
module pdp8_sram_bank
  import pdp8_mem_pkg::*;
#(
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce_d,
  input  logic              drv_d,
  input  logic              load,
  input  logic [DATA_W-1:0] wdata,
  output logic              ce_n,
  output logic              ub_n,
  output logic              lb_n,
  inout  wire [SRAM_D_W-1:0] io
);

  logic                drv_q;
  logic [SRAM_D_W-1:0] dout_q;

  // Byte enables track the chip enable; the PDP-8 never does byte accesses.
  always_ff @(posedge clk) begin
    if (reset) begin
      ce_n  <= 1'b1;
      ub_n  <= 1'b1;
      lb_n  <= 1'b1;
      drv_q <= 1'b0;
    end else begin
      ce_n  <= ~ce_d;
      ub_n  <= ~ce_d;
      lb_n  <= ~ce_d;
      drv_q <= drv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) dout_q <= SRAM_D_W'(wdata);
  end

  assign io = drv_q ? dout_q : 'z;

endmodule

// File: rtl/pdp8_sram_ctl.sv
// Registered request/acknowledge sequencer for the s3board asynchronous SRAMs,
// with programmable wait states, optional second bank and boot ROM read overlay.
module pdp8_sram_ctl
  import pdp8_mem_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 12,
  parameter int BANKS       = 1,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic                rom_hit,
  input  logic [DATA_W-1:0]   rom_data,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic [SRAM_A_W-1:0] sram_a,
  output logic                sram_oe_n,
  output logic                sram_we_n,
  inout  wire [SRAM_D_W-1:0]  sram1_io,
  inout  wire [SRAM_D_W-1:0]  sram2_io,
  output logic                sram1_ce_n,
  output logic                sram1_ub_n,
  output logic                sram1_lb_n,
  output logic                sram2_ce_n,
  output logic                sram2_ub_n,
  output logic                sram2_lb_n
);

  localparam int CNT_W  = $clog2(WAIT_CYCLES + 1);
  localparam int AW_EFF = (BANKS == 2) ? ADDR_W - 1 : ADDR_W;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_e          state, state_d;
  logic [CNT_W-1:0]    cnt, cnt_d;
  logic                bank_q, bank_d;
  logic                accept, rd_last, rom_rd;
  logic                active_d, drv_any_d;
  logic                addr_bank;
  logic [SRAM_A_W-1:0] addr_ext;
  logic [SRAM_D_W-1:0] rd_bus;
  logic                unused_rd;

  assign addr_bank = (BANKS == 2) ? addr[ADDR_W-1] : 1'b0;
  assign rd_bus    = bank_q ? sram2_io : sram1_io;
  assign unused_rd = ^rd_bus;
  assign rom_rd    = (state == S_IDLE) && req && rom_hit && !we;

  always_comb begin
    addr_ext             = '0;
    addr_ext[AW_EFF-1:0] = addr[AW_EFF-1:0];
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bank_d  = bank_q;
    accept  = 1'b0;
    rd_last = 1'b0;
    case (state)
      S_IDLE: begin
        if (req) begin
          // ROM region: reads take rom_data, writes are silently dropped.
          if (rom_hit) begin
            state_d = S_DONE;
          end else begin
            accept  = 1'b1;
            bank_d  = addr_bank;
            cnt_d   = CNT_LOAD;
            state_d = we ? S_WR : S_RD;
          end
        end
      end
      S_RD: begin
        if (cnt == CNT_ONE) begin
          rd_last = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt - CNT_ONE;
        end
      end
      S_WR: begin
        if (cnt == CNT_ONE) state_d = S_WR_HOLD;
        else                cnt_d   = cnt - CNT_ONE;
      end
      S_WR_HOLD: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  assign active_d  = (state_d == S_RD) || (state_d == S_WR) || (state_d == S_WR_HOLD);
  assign drv_any_d = (state_d == S_WR) || (state_d == S_WR_HOLD);

  // Outputs are registered from the next state so strobes change exactly on state edges.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bank_q    <= 1'b0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      rdata     <= '0;
      sram_a    <= '0;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bank_q    <= bank_d;
      ack       <= (state_d == S_DONE);
      busy      <= (state_d != S_IDLE);
      sram_oe_n <= (state_d != S_RD);
      sram_we_n <= (state_d != S_WR);
      if (accept) sram_a <= addr_ext;
      if (rom_rd)       rdata <= rom_data;
      else if (rd_last) rdata <= rd_bus[DATA_W-1:0];
    end
  end

  pdp8_sram_bank #(.DATA_W(DATA_W)) u_bank1 (
    .clk   (clk),
    .reset (reset),
    .ce_d  (active_d && !bank_d),
    .drv_d (drv_any_d && !bank_d),
    .load  (accept),
    .wdata (wdata),
    .ce_n  (sram1_ce_n),
    .ub_n  (sram1_ub_n),
    .lb_n  (sram1_lb_n),
    .io    (sram1_io)
  );

  generate
    if (BANKS == 2) begin : g_bank2
      pdp8_sram_bank #(.DATA_W(DATA_W)) u_bank2 (
        .clk   (clk),
        .reset (reset),
        .ce_d  (active_d && bank_d),
        .drv_d (drv_any_d && bank_d),
        .load  (accept),
        .wdata (wdata),
        .ce_n  (sram2_ce_n),
        .ub_n  (sram2_ub_n),
        .lb_n  (sram2_lb_n),
        .io    (sram2_io)
      );
    end else begin : g_no_bank2
      assign sram2_ce_n = 1'b1;
      assign sram2_ub_n = 1'b1;
      assign sram2_lb_n = 1'b1;
      assign sram2_io   = 'z;
    end
  endgenerate

endmodule

// File: tb/tb_pdp8_sram_ctl.sv
// Directed bench for pdp8_sram_ctl: three configurations with behavioural SRAMs.
`timescale 1ns/1ps
module tb_pdp8_sram_ctl;

  logic        clk;
  logic        reset;
  logic        we;
  logic        rom_hit;
  logic [15:0] addr;
  logic [11:0] wdata;
  logic [11:0] rom_data;

  logic        req    [3];
  logic        ack    [3];
  logic        busy   [3];
  logic [11:0] rdata  [3];
  logic [17:0] sram_a [3];
  logic        oe_n   [3];
  logic        we_n   [3];
  logic        ce1_n  [3];
  logic        ub1_n  [3];
  logic        lb1_n  [3];
  logic        ce2_n  [3];
  logic        ub2_n  [3];
  logic        lb2_n  [3];

  wire [15:0] io_a1, io_a2, io_b1, io_b2, io_c1, io_c2;

  logic [15:0] mem_a1 [0:255];
  logic [15:0] mem_b1 [0:255];
  logic [15:0] mem_b2 [0:255];
  logic [15:0] mem_c1 [0:255];

  int n_checks = 0;
  int n_errors = 0;
  int lat, m_oe, m_we, m_ce1, m_ce2, a_seen, bad;
  int m_ack, m_busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u_a: one bank, 2 wait states
  pdp8_sram_ctl #(.ADDR_W(15), .DATA_W(12), .BANKS(1), .WAIT_CYCLES(2)) u_a (
    .clk(clk), .reset(reset), .req(req[0]), .we(we), .addr(addr[14:0]), .wdata(wdata),
    .rom_hit(rom_hit), .rom_data(rom_data), .ack(ack[0]), .rdata(rdata[0]), .busy(busy[0]),
    .sram_a(sram_a[0]), .sram_oe_n(oe_n[0]), .sram_we_n(we_n[0]),
    .sram1_io(io_a1), .sram2_io(io_a2),
    .sram1_ce_n(ce1_n[0]), .sram1_ub_n(ub1_n[0]), .sram1_lb_n(lb1_n[0]),
    .sram2_ce_n(ce2_n[0]), .sram2_ub_n(ub2_n[0]), .sram2_lb_n(lb2_n[0])
  );

  // u_b: two banks, 4 wait states
  pdp8_sram_ctl #(.ADDR_W(16), .DATA_W(12), .BANKS(2), .WAIT_CYCLES(4)) u_b (
    .clk(clk), .reset(reset), .req(req[1]), .we(we), .addr(addr), .wdata(wdata),
    .rom_hit(rom_hit), .rom_data(rom_data), .ack(ack[1]), .rdata(rdata[1]), .busy(busy[1]),
    .sram_a(sram_a[1]), .sram_oe_n(oe_n[1]), .sram_we_n(we_n[1]),
    .sram1_io(io_b1), .sram2_io(io_b2),
    .sram1_ce_n(ce1_n[1]), .sram1_ub_n(ub1_n[1]), .sram1_lb_n(lb1_n[1]),
    .sram2_ce_n(ce2_n[1]), .sram2_ub_n(ub2_n[1]), .sram2_lb_n(lb2_n[1])
  );

  // u_c: one bank, 1 wait state
  pdp8_sram_ctl #(.ADDR_W(15), .DATA_W(12), .BANKS(1), .WAIT_CYCLES(1)) u_c (
    .clk(clk), .reset(reset), .req(req[2]), .we(we), .addr(addr[14:0]), .wdata(wdata),
    .rom_hit(rom_hit), .rom_data(rom_data), .ack(ack[2]), .rdata(rdata[2]), .busy(busy[2]),
    .sram_a(sram_a[2]), .sram_oe_n(oe_n[2]), .sram_we_n(we_n[2]),
    .sram1_io(io_c1), .sram2_io(io_c2),
    .sram1_ce_n(ce1_n[2]), .sram1_ub_n(ub1_n[2]), .sram1_lb_n(lb1_n[2]),
    .sram2_ce_n(ce2_n[2]), .sram2_ub_n(ub2_n[2]), .sram2_lb_n(lb2_n[2])
  );

  // Behavioural asynchronous SRAMs: drive on ce&oe, capture while ce&we are low.
  assign io_a1 = (!ce1_n[0] && !oe_n[0] && we_n[0]) ? mem_a1[sram_a[0][7:0]] : 16'bz;
  assign io_b1 = (!ce1_n[1] && !oe_n[1] && we_n[1]) ? mem_b1[sram_a[1][7:0]] : 16'bz;
  assign io_b2 = (!ce2_n[1] && !oe_n[1] && we_n[1]) ? mem_b2[sram_a[1][7:0]] : 16'bz;
  assign io_c1 = (!ce1_n[2] && !oe_n[2] && we_n[2]) ? mem_c1[sram_a[2][7:0]] : 16'bz;

  always @(posedge clk) begin
    if (!ce1_n[0] && !we_n[0]) mem_a1[sram_a[0][7:0]] <= io_a1;
    if (!ce1_n[1] && !we_n[1]) mem_b1[sram_a[1][7:0]] <= io_b1;
    if (!ce2_n[1] && !we_n[1]) mem_b2[sram_a[1][7:0]] <= io_b2;
    if (!ce1_n[2] && !we_n[2]) mem_c1[sram_a[2][7:0]] <= io_c1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // One access on DUT k; bit c of each mask is set when that strobe is low in cycle c.
  task automatic access(input int k, input logic w, input logic [15:0] a, input logic [11:0] d,
                        output int o_lat, output int o_oe, output int o_we, output int o_ce1,
                        output int o_ce2, output int o_a, output int o_bad);
    o_lat = -1; o_oe = 0; o_we = 0; o_ce1 = 0; o_ce2 = 0; o_a = -1; o_bad = 0;
    we = w; addr = a; wdata = d; req[k] = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      if (!oe_n[k])  o_oe  |= (1 << cyc);
      if (!we_n[k])  o_we  |= (1 << cyc);
      if (!ce1_n[k]) o_ce1 |= (1 << cyc);
      if (!ce2_n[k]) o_ce2 |= (1 << cyc);
      if (cyc == 1) o_a = int'(sram_a[k]);
      if (ub1_n[k] != ce1_n[k] || lb1_n[k] != ce1_n[k] ||
          ub2_n[k] != ce2_n[k] || lb2_n[k] != ce2_n[k]) o_bad++;
      if (ack[k]) begin
        o_lat = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; rom_hit = 1'b0; rom_data = '0;
    for (int k = 0; k < 3; k++) req[k] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_pins%0d", k),
               int'({ack[k], busy[k], oe_n[k], we_n[k], ce1_n[k], ub1_n[k], lb1_n[k],
                     ce2_n[k], ub2_n[k], lb2_n[k]}), 'h0FF);
      check_eq($sformatf("rst_rdata%0d", k), int'(rdata[k]), 0);
      check_eq($sformatf("rst_sram_a%0d", k), int'(sram_a[k]), 0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Single bank, 2 wait states: write then read back 0o7777 at 0o200
    access(0, 1'b1, 16'o200, 12'o7777, lat, m_oe, m_we, m_ce1, m_ce2, a_seen, bad);
    check_eq("a_wr_lat", lat, 4);
    check_eq("a_wr_we_mask", m_we, 6);
    check_eq("a_wr_oe_mask", m_oe, 0);
    check_eq("a_wr_ce1_mask", m_ce1, 14);
    check_eq("a_wr_ce2_mask", m_ce2, 0);
    check_eq("a_wr_sram_a", a_seen, 'o200);
    check_eq("a_wr_ublb", bad, 0);
    access(0, 1'b0, 16'o200, 12'o0, lat, m_oe, m_we, m_ce1, m_ce2, a_seen, bad);
    check_eq("a_rd_lat", lat, 3);
    check_eq("a_rd_oe_mask", m_oe, 6);
    check_eq("a_rd_we_mask", m_we, 0);
    check_eq("a_rd_ce1_mask", m_ce1, 6);
    check_eq("a_rd_data", int'(rdata[0]), 'o7777);
    repeat (2) @(posedge clk);
    #1;
    check_eq("a_rd_data_held", int'(rdata[0]), 'o7777);

    // Boot ROM overlay: read returns rom_data, write is dropped, no strobes
    rom_hit = 1'b1; rom_data = 12'o6032;
    access(0, 1'b0, 16'o7600, 12'o0, lat, m_oe, m_we, m_ce1, m_ce2, a_seen, bad);
    check_eq("rom_rd_lat", lat, 1);
    check_eq("rom_rd_strobes", m_oe | m_we | m_ce1 | m_ce2, 0);
    check_eq("rom_rd_data", int'(rdata[0]), 'o6032);
    access(0, 1'b1, 16'o200, 12'o0055, lat, m_oe, m_we, m_ce1, m_ce2, a_seen, bad);
    check_eq("rom_wr_lat", lat, 1);
    check_eq("rom_wr_strobes", m_oe | m_we | m_ce1 | m_ce2, 0);
    check_eq("rom_wr_rdata_kept", int'(rdata[0]), 'o6032);
    rom_hit = 1'b0;

    // Back-to-back reads with req held: acks in cycles 3 and 7
    m_ack = 0; m_oe = 0; m_busy = 0;
    we = 1'b0; addr = 16'o200; req[0] = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (ack[0])   m_ack  |= (1 << cyc);
      if (!oe_n[0]) m_oe   |= (1 << cyc);
      if (busy[0])  m_busy |= (1 << cyc);
    end
    req[0] = 1'b0;
    check_eq("b2b_ack_mask", m_ack, 136);
    check_eq("b2b_oe_mask", m_oe, 102);
    check_eq("b2b_busy_mask", m_busy, 238);
    check_eq("b2b_rdata", int'(rdata[0]), 'o7777);
    @(posedge clk); #1;

    // Reset during cycle 1 of a write aborts it without an ack
    we = 1'b1; addr = 16'o300; wdata = 12'o1111; req[0] = 1'b1;
    @(posedge clk); #1;
    check_eq("rstw_cyc1_we_n", int'(we_n[0]), 0);
    reset = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    check_eq("rstw_pins", int'({ack[0], busy[0], oe_n[0], we_n[0], ce1_n[0], ub1_n[0], lb1_n[0]}),
             'h1F);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("rstw_no_ack", int'({ack[0], busy[0]}), 0);
    access(0, 1'b0, 16'o200, 12'o0, lat, m_oe, m_we, m_ce1, m_ce2, a_seen, bad);
    check_eq("rstw_next_lat", lat, 3);
    check_eq("rstw_next_data", int'(rdata[0]), 'o7777);

    // Two banks, 4 wait states: MSB selects the bank, same SRAM address
    access(1, 1'b1, 16'h8005, 12'o1234, lat, m_oe, m_we, m_ce1, m_ce2, a_seen, bad);
    check_eq("b_wr2_lat", lat, 6);
    check_eq("b_wr2_sram_a", a_seen, 5);
    check_eq("b_wr2_we_mask", m_we, 30);
    check_eq("b_wr2_ce2_mask", m_ce2, 62);
    check_eq("b_wr2_ce1_mask", m_ce1, 0);
    check_eq("b_wr2_ublb", bad, 0);
    access(1, 1'b1, 16'h0005, 12'o4321, lat, m_oe, m_we, m_ce1, m_ce2, a_seen, bad);
    check_eq("b_wr1_lat", lat, 6);
    check_eq("b_wr1_sram_a", a_seen, 5);
    check_eq("b_wr1_ce1_mask", m_ce1, 62);
    check_eq("b_wr1_ce2_mask", m_ce2, 0);
    access(1, 1'b0, 16'h8005, 12'o0, lat, m_oe, m_we, m_ce1, m_ce2, a_seen, bad);
    check_eq("b_rd2_lat", lat, 5);
    check_eq("b_rd2_oe_mask", m_oe, 30);
    check_eq("b_rd2_ce2_mask", m_ce2, 30);
    check_eq("b_rd2_ce1_mask", m_ce1, 0);
    check_eq("b_rd2_data", int'(rdata[1]), 'o1234);
    access(1, 1'b0, 16'h0005, 12'o0, lat, m_oe, m_we, m_ce1, m_ce2, a_seen, bad);
    check_eq("b_rd1_lat", lat, 5);
    check_eq("b_rd1_ce1_mask", m_ce1, 30);
    check_eq("b_rd1_ce2_mask", m_ce2, 0);
    check_eq("b_rd1_data", int'(rdata[1]), 'o4321);

    // Single wait state: write latency 3, read latency 2
    access(2, 1'b1, 16'o10, 12'o0525, lat, m_oe, m_we, m_ce1, m_ce2, a_seen, bad);
    check_eq("c_wr_lat", lat, 3);
    check_eq("c_wr_we_mask", m_we, 2);
    check_eq("c_wr_ce1_mask", m_ce1, 6);
    access(2, 1'b0, 16'o10, 12'o0, lat, m_oe, m_we, m_ce1, m_ce2, a_seen, bad);
    check_eq("c_rd_lat", lat, 2);
    check_eq("c_rd_oe_mask", m_oe, 2);
    check_eq("c_rd_data", int'(rdata[2]), 'o0525);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
